sdram_init_seq: RTL and testbench
=================================

Name: sdram_init_seq

Overview:
- Power-up initialisation sequencer for the SDRAM controller.
- Drives the JEDEC init command stream onto the SDRAM command/address pins after reset: NOP hold, precharge-all, N auto-refreshes, then load-mode-register.
- Sits directly upstream of the SDRAM pins and the controller's normal command path.
- Raises init_done to hand the pins over to the normal command path; the whitebox init assertions check this stream.

Parameters:
- T_INIT, 500, NOP cycles after start before precharge (>=1)
- T_RP, 3, precharge-to-next-command cycles (>=1)
- T_RFC, 7, refresh-to-next-command cycles (>=1)
- T_MRD, 2, mode-register-set to init_done cycles (>=1)
- N_REFRESH, 2, number of auto-refresh commands (>=1)
- ADDR_W, 13, SDRAM address width (>=11)
- BA_W, 2, bank address width

Ports:
- sdram_clk  in  1  SDRAM clock; all state changes on rising edge
- sdram_resetn  in  1  asynchronous active-low reset
- cfg_en  in  1  start request, level; sampled only in IDLE
- cfg_mode_reg  in  ADDR_W  mode register value; captured when start is accepted
- sdr_cke  out  1  clock enable
- sdr_cs_n  out  1  chip select
- sdr_ras_n  out  1  row address strobe
- sdr_cas_n  out  1  column address strobe
- sdr_we_n  out  1  write enable
- sdr_addr  out  ADDR_W  address bus
- sdr_ba  out  BA_W  bank address
- init_busy  out  1  high while the sequence runs
- init_done  out  1  sticky high once the sequence completes

Behaviour:
- All outputs are registered. No combinational path from inputs to outputs.
- Command encodings, as {cs_n,ras_n,cas_n,we_n}:
  - NOP = 0111
  - PRE = 0010, addr[10]=1, other addr bits 0, ba=0
  - REF = 0001, addr=0, ba=0
  - MRS = 0000, addr=captured mode, ba=0
  - IDLE pins = 1111, addr=0, ba=0
- Reset (async assert, sync release): state=IDLE, cke=0, cs_n/ras_n/cas_n/we_n=1, addr=0, ba=0, init_busy=0, init_done=0, counters=0.
- States: IDLE, WAIT_INIT, PRE, WAIT_RP, REF, WAIT_RFC, MRS, WAIT_MRD, DONE.
- IDLE: if cfg_en=1 at edge E, capture cfg_mode_reg and go to WAIT_INIT. From E onward: cke=1, init_busy=1.
- Timeline, cycle 0 = first cycle after E, general form:
  - NOP on cycles 0..T_INIT-1
  - PRE on cycle T_INIT
  - NOP for T_RP-1 cycles
  - REF k (k=0..N_REFRESH-1) on cycle T_INIT+T_RP+k*T_RFC, each followed by T_RFC-1 NOPs
  - MRS on cycle M = T_INIT+T_RP+N_REFRESH*T_RFC
  - NOP for T_MRD-1 cycles
  - DONE entered at cycle M+T_MRD
- Timeline with defaults: PRE@500, REF@503 and @510, MRS@517, init_done=1@519.
- Each command is exactly one cycle wide.
- Wait counter: width clog2 of the largest wait; loaded on state entry, counts down, transitions at 0. A wait of 1 cycle (T_x=1) means zero NOPs between commands.
- Refresh counter counts issued REFs. After REF, WAIT_RFC exits to REF if count<N_REFRESH, otherwise to MRS.
- DONE:
  - init_done=1 and init_busy=0 at the same edge.
  - Pins return to NOP 0111, cke=1.
  - State holds until reset. cfg_en is ignored.
- cfg_en deasserted mid-sequence: ignored; the sequence completes.
- cfg_mode_reg changes after capture: no effect.
- Reset asserted mid-sequence: immediate return to reset values. A new start requires cfg_en after reset release.
- cfg_en high during reset release: start is accepted on the first active edge after release.
- init_busy and init_done are never both 1.

Test Plan:
- Defaults; reset released; cfg_en=1 at edge E with cfg_mode_reg=13'h033 -> pins NOP(0111) for 500 cycles; PRE with addr=13'h400 @500; REF @503 and @510; MRS with addr=13'h033 @517; init_done=1 and init_busy=0 @519; pins NOP afterwards.
- Hold cfg_en=0 for 1000 cycles after reset -> pins stay 1111, cke=0, init_busy=0, init_done=0.
- Assert sdram_resetn=0 asynchronously at cycle 505 (between refreshes) -> all outputs at reset values before the next edge; restart with cfg_en -> full timeline repeats from cycle 0.
- Pulse cfg_en for 1 cycle, change cfg_mode_reg to 13'h1FF at cycle 10 -> full sequence completes and MRS addr=13'h033.
- Parameters T_INIT=4, T_RP=1, T_RFC=1, T_MRD=1, N_REFRESH=3 -> PRE@4, REF@5, @6 and @7, MRS@8, init_done@9; each command exactly one cycle wide, no extra NOPs.
- After init_done, toggle cfg_en repeatedly for 100 cycles -> outputs unchanged: NOP pins, init_done=1, init_busy=0.

Source files
------------

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer: NOP hold, precharge-all, N auto-refreshes,
// then mode-register set, after which init_done hands the pins to the normal command path.
module sdram_init_seq #(
  parameter int T_INIT    = 500,
  parameter int T_RP      = 3,
  parameter int T_RFC     = 7,
  parameter int T_MRD     = 2,
  parameter int N_REFRESH = 2,
  parameter int ADDR_W    = 13,
  parameter int BA_W      = 2
) (
  input  logic              sdram_clk,
  input  logic              sdram_resetn,
  input  logic              cfg_en,
  input  logic [ADDR_W-1:0] cfg_mode_reg,
  output logic              sdr_cke,
  output logic              sdr_cs_n,
  output logic              sdr_ras_n,
  output logic              sdr_cas_n,
  output logic              sdr_we_n,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [BA_W-1:0]   sdr_ba,
  output logic              init_busy,
  output logic              init_done
);

  localparam int MAX_WAIT = (T_INIT > T_RP && T_INIT > T_RFC && T_INIT > T_MRD) ? T_INIT :
                            (T_RP > T_RFC && T_RP > T_MRD) ? T_RP :
                            (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int RC_W  = $clog2(N_REFRESH + 1);

  // Wait states follow a one-cycle command, so they hold T_x-1 cycles (load T_x-2).
  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(T_INIT - 1);
  localparam logic [CNT_W-1:0] LD_RP   = CNT_W'((T_RP > 1) ? T_RP - 2 : 0);
  localparam logic [CNT_W-1:0] LD_RFC  = CNT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [CNT_W-1:0] LD_MRD  = CNT_W'((T_MRD > 1) ? T_MRD - 2 : 0);
  localparam logic [RC_W-1:0]  N_REF   = RC_W'(N_REFRESH);

  localparam logic [3:0] CMD_IDLE = 4'b1111;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WAIT_INIT, ST_PRE, ST_WAIT_RP, ST_REF,
    ST_WAIT_RFC, ST_MRS, ST_WAIT_MRD, ST_DONE
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [CNT_W-1:0]    wait_cnt_r, wait_cnt_nxt_s;
  logic [RC_W-1:0]     ref_cnt_r, ref_cnt_nxt_s;
  logic [ADDR_W-1:0]   mode_r, mode_nxt_s;

  logic                cke_s, busy_s, done_s;
  logic [3:0]          cmd_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [BA_W-1:0]     ba_s;

  logic                cke_r, busy_r, done_r;
  logic [3:0]          cmd_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [BA_W-1:0]     ba_r;

  // Next-state, wait counter, refresh counter and mode capture.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    ref_cnt_nxt_s  = ref_cnt_r;
    mode_nxt_s     = mode_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_en) begin
          state_nxt_s    = ST_WAIT_INIT;
          wait_cnt_nxt_s = LD_INIT;
          ref_cnt_nxt_s  = '0;
          mode_nxt_s     = cfg_mode_reg;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_INIT: begin
        if (wait_cnt_r == '0) begin
          state_nxt_s = ST_PRE;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r - 1'b1;
        end
      end
      ST_PRE: begin
        if (T_RP > 1) begin
          state_nxt_s    = ST_WAIT_RP;
          wait_cnt_nxt_s = LD_RP;
        end else begin
          state_nxt_s = ST_REF;
        end
      end
      ST_WAIT_RP: begin
        if (wait_cnt_r == '0) begin
          state_nxt_s = ST_REF;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r - 1'b1;
        end
      end
      ST_REF: begin
        ref_cnt_nxt_s = ref_cnt_r + 1'b1;
        if (T_RFC > 1) begin
          state_nxt_s    = ST_WAIT_RFC;
          wait_cnt_nxt_s = LD_RFC;
        end else if (ref_cnt_nxt_s < N_REF) begin
          state_nxt_s = ST_REF;
        end else begin
          state_nxt_s = ST_MRS;
        end
      end
      ST_WAIT_RFC: begin
        if (wait_cnt_r != '0) begin
          wait_cnt_nxt_s = wait_cnt_r - 1'b1;
        end else if (ref_cnt_r < N_REF) begin
          state_nxt_s = ST_REF;
        end else begin
          state_nxt_s = ST_MRS;
        end
      end
      ST_MRS: begin
        if (T_MRD > 1) begin
          state_nxt_s    = ST_WAIT_MRD;
          wait_cnt_nxt_s = LD_MRD;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_WAIT_MRD: begin
        if (wait_cnt_r == '0) begin
          state_nxt_s = ST_DONE;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r - 1'b1;
        end
      end
      ST_DONE: state_nxt_s = ST_DONE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Pin decode from the upcoming state so the pin registers change with the state.
  always_comb begin
    cke_s  = 1'b1;
    cmd_s  = CMD_NOP;
    addr_s = '0;
    ba_s   = '0;
    busy_s = 1'b1;
    done_s = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        cke_s  = 1'b0;
        cmd_s  = CMD_IDLE;
        busy_s = 1'b0;
      end
      ST_PRE: begin
        cmd_s      = CMD_PRE;
        addr_s[10] = 1'b1;
      end
      ST_REF:  cmd_s = CMD_REF;
      ST_MRS: begin
        cmd_s  = CMD_MRS;
        addr_s = mode_nxt_s;
      end
      ST_DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      ST_WAIT_INIT, ST_WAIT_RP, ST_WAIT_RFC, ST_WAIT_MRD: cmd_s = CMD_NOP;
      default: begin
        cke_s  = 1'b0;
        cmd_s  = CMD_IDLE;
        busy_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered pin outputs.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= '0;
      ref_cnt_r  <= '0;
      mode_r     <= '0;
      cke_r      <= 1'b0;
      cmd_r      <= CMD_IDLE;
      addr_r     <= '0;
      ba_r       <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      ref_cnt_r  <= ref_cnt_nxt_s;
      mode_r     <= mode_nxt_s;
      cke_r      <= cke_s;
      cmd_r      <= cmd_s;
      addr_r     <= addr_s;
      ba_r       <= ba_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign sdr_cke   = cke_r;
  assign sdr_cs_n  = cmd_r[3];
  assign sdr_ras_n = cmd_r[2];
  assign sdr_cas_n = cmd_r[1];
  assign sdr_we_n  = cmd_r[0];
  assign sdr_addr  = addr_r;
  assign sdr_ba    = ba_r;
  assign init_busy = busy_r;
  assign init_done = done_r;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Randomized bench for sdram_init_seq: a default-timing instance and a minimal-timing
// instance, both compared every cycle against a timeline model built from the command schedule.
module tb_sdram_init_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic [12:0] mode_a, mode_b;

  logic        a_cke, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_busy, a_done;
  logic [12:0] a_addr;
  logic [1:0]  a_ba;
  logic        b_cke, b_cs_n, b_ras_n, b_cas_n, b_we_n, b_busy, b_done;
  logic [12:0] b_addr;
  logic [1:0]  b_ba;

  int n_checks = 0;
  int n_errors = 0;

  bit          started_a = 1'b0, started_b = 1'b0;
  int          cyc_a = 0, cyc_b = 0;
  logic [12:0] mexp_a = 13'h0, mexp_b = 13'h0;

  always #5 clk = ~clk;

  sdram_init_seq u_dut_a (
    .sdram_clk(clk), .sdram_resetn(rst_n), .cfg_en(en_a), .cfg_mode_reg(mode_a),
    .sdr_cke(a_cke), .sdr_cs_n(a_cs_n), .sdr_ras_n(a_ras_n), .sdr_cas_n(a_cas_n),
    .sdr_we_n(a_we_n), .sdr_addr(a_addr), .sdr_ba(a_ba),
    .init_busy(a_busy), .init_done(a_done)
  );

  sdram_init_seq #(
    .T_INIT(4), .T_RP(1), .T_RFC(1), .T_MRD(1), .N_REFRESH(3)
  ) u_dut_b (
    .sdram_clk(clk), .sdram_resetn(rst_n), .cfg_en(en_b), .cfg_mode_reg(mode_b),
    .sdr_cke(b_cke), .sdr_cs_n(b_cs_n), .sdr_ras_n(b_ras_n), .sdr_cas_n(b_cas_n),
    .sdr_we_n(b_we_n), .sdr_addr(b_addr), .sdr_ba(b_ba),
    .init_busy(b_busy), .init_done(b_done)
  );

  // Expected {cke, cs_n, ras_n, cas_n, we_n, addr, ba, busy, done} at cycle cyc after start.
  function automatic logic [21:0] model(input bit started, input int cyc, input logic [12:0] mode,
                                        input int ti, input int trp, input int trfc,
                                        input int tmrd, input int nref);
    int m;
    logic [12:0] pre_addr;
    m = ti + trp + nref * trfc;
    pre_addr = 13'h400;
    if (!started)
      return {1'b0, 4'b1111, 13'h0, 2'b00, 1'b0, 1'b0};
    if (cyc >= m + tmrd)
      return {1'b1, 4'b0111, 13'h0, 2'b00, 1'b0, 1'b1};
    if (cyc == ti)
      return {1'b1, 4'b0010, pre_addr, 2'b00, 1'b1, 1'b0};
    if (cyc >= ti + trp && cyc < m && ((cyc - ti - trp) % trfc) == 0)
      return {1'b1, 4'b0001, 13'h0, 2'b00, 1'b1, 1'b0};
    if (cyc == m)
      return {1'b1, 4'b0000, mode, 2'b00, 1'b1, 1'b0};
    return {1'b1, 4'b0111, 13'h0, 2'b00, 1'b1, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_both();
    check($sformatf("a_pins cyc=%0d", cyc_a),
          {10'h0, a_cke, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_addr, a_ba, a_busy, a_done},
          {10'h0, model(started_a, cyc_a, mexp_a, 500, 3, 7, 2, 2)});
    check($sformatf("b_pins cyc=%0d", cyc_b),
          {10'h0, b_cke, b_cs_n, b_ras_n, b_cas_n, b_we_n, b_addr, b_ba, b_busy, b_done},
          {10'h0, model(started_b, cyc_b, mexp_b, 4, 1, 1, 1, 3)});
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      started_a = 1'b0; cyc_a = 0;
      started_b = 1'b0; cyc_b = 0;
    end else begin
      if (started_a) cyc_a++;
      else if (en_a) begin started_a = 1'b1; cyc_a = 0; mexp_a = mode_a; end
      if (started_b) cyc_b++;
      else if (en_b) begin started_b = 1'b1; cyc_b = 0; mexp_b = mode_b; end
    end
    @(negedge clk);
    check_both();
  endtask

  initial begin
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; mode_a = 13'h0; mode_b = 13'h0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Idle hold: no start for 1000 cycles.
    for (int i = 0; i < 1000; i++) begin
      mode_a = 13'($urandom); mode_b = 13'($urandom);
      tick();
    end

    // Single-cycle start pulse; mode input changes after capture.
    en_a = 1'b1; mode_a = 13'h033;
    en_b = 1'b1; mode_b = 13'($urandom);
    tick();
    en_a = 1'b0; en_b = 1'b0;
    while (cyc_a < 505) begin
      if (cyc_a == 9) mode_a = 13'h1FF;
      en_b = 1'($urandom);
      mode_b = 13'($urandom);
      tick();
    end

    // Asynchronous reset between refreshes, checked before the next edge.
    #2 rst_n = 1'b0;
    #1;
    started_a = 1'b0; cyc_a = 0; started_b = 1'b0; cyc_b = 0;
    check_both();
    tick();

    // Release with start already requested.
    rst_n = 1'b1; en_a = 1'b1; mode_a = 13'($urandom); en_b = 1'b0;
    tick();
    while (cyc_a < 540) begin
      en_a = 1'($urandom);
      mode_a = 13'($urandom);
      tick();
    end

    // cfg_en toggling after completion is ignored.
    for (int i = 0; i < 100; i++) begin
      en_a = ~en_a; en_b = 1'($urandom);
      mode_a = 13'($urandom); mode_b = 13'($urandom);
      tick();
    end

    // Randomized restarts through reset.
    for (int it = 0; it < 20; it++) begin
      rst_n = 1'b0; en_a = 1'($urandom); en_b = 1'($urandom);
      tick();
      rst_n = 1'b1; en_a = 1'b0; en_b = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      en_a = 1'b1; en_b = 1'b1;
      mode_a = 13'($urandom); mode_b = 13'($urandom);
      tick();
      for (int k = 0; k < 14; k++) begin
        en_a = 1'($urandom); en_b = 1'($urandom);
        mode_a = 13'($urandom); mode_b = 13'($urandom);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
